// File: rtl/photonic_adc_accumulator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : photonic_adc_accumulator_if
// Purpose : Sample-in / result-out AXI-Stream bundle of the ADC accumulator.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
interface photonic_adc_accumulator_if #(
  parameter int ACC_WIDTH = 24
);
  logic [255:0]          s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [ACC_WIDTH-1:0]  m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  // Accumulator side: consumes samples, produces results.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  // Environment side: produces samples, consumes results.
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/photonic_adc_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : photonic_adc_accumulator
// Purpose : Frames the free-running multiplier ADC stream after a start pulse,
//           sums VECTOR_LEN 8-bit magnitudes into one saturating dot-product
//           result and offers it on a one-entry AXI-Stream output register.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module photonic_adc_accumulator #(
  parameter int VECTOR_LEN   = 784,
  parameter int START_OFFSET = 10,
  parameter int ACC_WIDTH    = 24
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    start,
  photonic_adc_accumulator_if.slave    bus,
  output logic                         busy,
  output logic                         overflow_err
);

  localparam int NUM_BEATS = VECTOR_LEN / 16;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  // The wait counter holds START_OFFSET-2 so the ACCUM transition happens
  // on the cycle it reads zero; offsets 0 and 1 never use it.
  localparam int OFF_W     = (START_OFFSET > 2) ? $clog2(START_OFFSET - 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [OFF_W-1:0]  OFF_LOAD  = OFF_W'((START_OFFSET > 2) ? START_OFFSET - 2 : 0);

  if (VECTOR_LEN < 16 || (VECTOR_LEN % 16) != 0 || ACC_WIDTH < 12) begin : g_bad_params
    $error("photonic_adc_accumulator: VECTOR_LEN must be a multiple of 16 >= 16 and ACC_WIDTH >= 12");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OFF_W-1:0]      off_cnt_q, off_cnt_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_first_q, s1_first_d;
  logic                  s1_last_q, s1_last_d;
  logic [11:0]           s1_sum_q, s1_sum_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ovf_q, ovf_d;

  logic [11:0]           lane_sum;
  logic                  beat_take;
  logic [ACC_WIDTH:0]    sum_wide;
  logic                  sum_sat;
  logic [ACC_WIDTH-1:0]  sum_clamped;
  logic                  out_accept;
  logic                  unused_lane_bits;

  // Only bits [g*16+7 +: 8] of each lane carry magnitude; the rest is noise.
  assign unused_lane_bits = ^bus.s_axis_tdata;

  // Add the 16 unsigned 8-bit lane magnitudes of the current beat.
  always_comb begin
    lane_sum = '0;
    for (int g = 0; g < 16; g++) begin
      lane_sum = lane_sum + 12'(bus.s_axis_tdata[g*16+7 +: 8]);
    end
  end

  // Framing FSM: skip the multiplier latency, then count valid beats.
  always_comb begin
    state_d    = state_q;
    off_cnt_d  = off_cnt_q;
    beat_cnt_d = beat_cnt_q;
    // With zero offset the start cycle itself carries beat 0.
    beat_take  = bus.s_axis_tvalid &&
                 ((state_q == S_ACCUM) ||
                  (state_q == S_IDLE && start && START_OFFSET == 0));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (START_OFFSET <= 1) begin
            state_d = S_ACCUM;
          end else begin
            state_d   = S_WAIT;
            off_cnt_d = OFF_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (off_cnt_q == '0) begin
          state_d = S_ACCUM;
        end else begin
          off_cnt_d = off_cnt_q - OFF_W'(1);
        end
      end
      S_ACCUM: begin
        state_d = S_ACCUM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (beat_take) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
        state_d    = S_IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  // Two-stage datapath: register the lane sum, then accumulate / publish.
  always_comb begin
    s1_valid_d = beat_take;
    s1_sum_d   = lane_sum;
    s1_first_d = (beat_cnt_q == '0);
    s1_last_d  = (beat_cnt_q == LAST_BEAT);

    sum_wide    = (s1_first_q ? {(ACC_WIDTH+1){1'b0}} : {1'b0, acc_q}) + (ACC_WIDTH+1)'(s1_sum_q);
    sum_sat     = sum_wide[ACC_WIDTH];
    sum_clamped = sum_sat ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];

    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q | (s1_valid_q & sum_sat);
    out_accept  = out_valid_q & bus.m_axis_tready;

    if (s1_valid_q && !s1_last_q) begin
      acc_d = sum_clamped;
    end
    if (out_accept) begin
      out_valid_d = 1'b0;
    end
    // A finished vector replaces the held result only if that slot is free
    // or being emptied this very edge; otherwise it is lost and flagged.
    if (s1_valid_q && s1_last_q) begin
      if (!out_valid_q || out_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = sum_clamped;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State, pipeline and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      off_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_cnt_q   <= off_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.s_axis_tready = 1'b1;
  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tvalid = out_valid_q;
  assign busy              = (state_q != S_IDLE);
  assign overflow_err      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_photonic_adc_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module  : tb_photonic_adc_accumulator
// Purpose : Self-checking bench; a 24-bit and a 12-bit accumulator share the
//           same stimulus, results are checked in order against queues.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_photonic_adc_accumulator;

  localparam int VL = 32;
  localparam int SO = 2;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic [255:0] tdata  = '0;
  logic         tvalid = 1'b0;
  logic         tready = 1'b1;
  logic         busy_a, busy_b, ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  logic [23:0] qa[$];
  logic [11:0] qb[$];

  photonic_adc_accumulator_if #(.ACC_WIDTH(24)) bus_a ();
  photonic_adc_accumulator_if #(.ACC_WIDTH(12)) bus_b ();

  assign bus_a.s_axis_tdata  = tdata;
  assign bus_a.s_axis_tvalid = tvalid;
  assign bus_a.m_axis_tready = tready;
  assign bus_b.s_axis_tdata  = tdata;
  assign bus_b.s_axis_tvalid = tvalid;
  assign bus_b.m_axis_tready = tready;

  photonic_adc_accumulator #(.VECTOR_LEN(VL), .START_OFFSET(SO), .ACC_WIDTH(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a),
    .busy(busy_a), .overflow_err(ovf_a)
  );

  photonic_adc_accumulator #(.VECTOR_LEN(VL), .START_OFFSET(SO), .ACC_WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_b),
    .busy(busy_b), .overflow_err(ovf_b)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] beat(input logic [15:0] lane);
    return {16{lane}};
  endfunction

  function automatic logic [11:0] sat12(input int v);
    return (v > 4095) ? 12'hFFF : 12'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v);
    qa.push_back(24'(v));
    qb.push_back(sat12(v));
  endtask

  // Scoreboard: every accepted result is popped and compared in order.
  always @(negedge clk) begin
    logic [23:0] ea;
    logic [11:0] eb;
    if (rst_n && bus_a.m_axis_tvalid && bus_a.m_axis_tready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL result_a: got unexpected %0d, required no result", bus_a.m_axis_tdata);
      end else begin
        ea = qa.pop_front();
        if (bus_a.m_axis_tdata !== ea) begin
          errors++;
          $display("FAIL result_a: got %0d, required %0d", bus_a.m_axis_tdata, ea);
        end
      end
    end
    if (rst_n && bus_b.m_axis_tvalid && bus_b.m_axis_tready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL result_b: got unexpected %0d, required no result", bus_b.m_axis_tdata);
      end else begin
        eb = qb.pop_front();
        if (bus_b.m_axis_tdata !== eb) begin
          errors++;
          $display("FAIL result_b: got %0d, required %0d", bus_b.m_axis_tdata, eb);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.m_axis_tvalid !== 1'b0 || bus_a.m_axis_tdata !== 24'd0) begin
      errors++;
      $display("FAIL reset_out_a: got v=%b d=%0d, required v=0 d=0", bus_a.m_axis_tvalid, bus_a.m_axis_tdata);
    end
    checks++;
    if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags_a: got busy=%b ovf=%b, required 0 0", busy_a, ovf_a);
    end
    checks++;
    if (bus_b.m_axis_tvalid !== 1'b0 || busy_b !== 1'b0 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: got v=%b busy=%b ovf=%b, required 0 0 0", bus_b.m_axis_tvalid, busy_b, ovf_b);
    end
    checks++;
    if (bus_a.s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL s_tready: got %b, required 1", bus_a.s_axis_tready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    tready = 1'b1;
    tvalid = 1'b1;
    tdata  = beat(16'h0080);
    start  = 1'b1;
    push_exp(32);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (busy_a !== (c >= 1 && c <= 3)) begin
        errors++;
        $display("FAIL basic_busy c%0d: got %b, required %b", c, busy_a, (c >= 1 && c <= 3));
      end
      checks++;
      if (bus_a.m_axis_tvalid !== (c == 5)) begin
        errors++;
        $display("FAIL basic_tvalid c%0d: got %b, required %b", c, bus_a.m_axis_tvalid, (c == 5));
      end
      tick();
      start = 1'b0;
    end
  endtask

  task automatic test_saturate();
    tdata = beat(16'hFFFF);
    start = 1'b1;
    push_exp(8160);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus_b.m_axis_tvalid !== (c == 5)) begin
        errors++;
        $display("FAIL sat_tvalid_b c%0d: got %b, required %b", c, bus_b.m_axis_tvalid, (c == 5));
      end
      tick();
      start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_a: got %b, required 0", ovf_a);
    end
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf_b: got %b, required 1", ovf_b);
    end
    tick();
  endtask

  task automatic test_gaps();
    tdata = beat(16'h0100);
    start = 1'b1;
    push_exp(64);
    for (int c = 0; c < 10; c++) begin
      tvalid = (c == 2 || c == 5);
      @(negedge clk);
      checks++;
      if (bus_a.m_axis_tvalid !== (c == 7)) begin
        errors++;
        $display("FAIL gaps_tvalid c%0d: got %b, required %b", c, bus_a.m_axis_tvalid, (c == 7));
      end
      checks++;
      if (busy_a !== (c >= 1 && c <= 5)) begin
        errors++;
        $display("FAIL gaps_busy c%0d: got %b, required %b", c, busy_a, (c >= 1 && c <= 5));
      end
      tick();
      start = 1'b0;
    end
    tvalid = 1'b1;
  endtask

  task automatic test_back_to_back();
    tready = 1'b0;
    tvalid = 1'b1;
    push_exp(32);
    for (int c = 0; c < 12; c++) begin
      start = (c == 0 || c == 4);
      tdata = (c < 4) ? beat(16'h0080) : beat(16'h0100);
      @(negedge clk);
      checks++;
      if (bus_a.m_axis_tvalid !== (c >= 5)) begin
        errors++;
        $display("FAIL bp_tvalid c%0d: got %b, required %b", c, bus_a.m_axis_tvalid, (c >= 5));
      end
      checks++;
      if (ovf_a !== (c >= 9)) begin
        errors++;
        $display("FAIL bp_ovf c%0d: got %b, required %b", c, ovf_a, (c >= 9));
      end
      if (c >= 5) begin
        checks++;
        if (bus_a.m_axis_tdata !== 24'd32) begin
          errors++;
          $display("FAIL bp_hold c%0d: got %0d, required 32", c, bus_a.m_axis_tdata);
        end
      end
      tick();
    end
    start  = 1'b0;
    tready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus_a.m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got tvalid %b, required 0", bus_a.m_axis_tvalid);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    tready = 1'b1;
    tvalid = 1'b1;
    push_exp(32);
    push_exp(64);
    for (int c = 0; c < 12; c++) begin
      start = (c == 0 || c == 2 || c == 4);
      tdata = (c < 4) ? beat(16'h0080) : beat(16'h0100);
      @(negedge clk);
      checks++;
      if (bus_a.m_axis_tvalid !== (c == 5 || c == 9)) begin
        errors++;
        $display("FAIL ign_tvalid c%0d: got %b, required %b", c, bus_a.m_axis_tvalid, (c == 5 || c == 9));
      end
      checks++;
      if (busy_a !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))) begin
        errors++;
        $display("FAIL ign_busy c%0d: got %b, required %b", c, busy_a, ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    tdata = beat(16'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || bus_a.m_axis_tvalid !== 1'b0 || bus_a.m_axis_tdata !== 24'd0) begin
      errors++;
      $display("FAIL midrst_out: got busy=%b v=%b d=%0d, required 0 0 0", busy_a, bus_a.m_axis_tvalid, bus_a.m_axis_tdata);
    end
    checks++;
    if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ovf: got a=%b b=%b, required 0 0", ovf_a, ovf_b);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tdata = beat(16'h0080);
    start = 1'b1;
    push_exp(32);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus_a.m_axis_tvalid !== (c == 5)) begin
        errors++;
        $display("FAIL midrst_tvalid c%0d: got %b, required %b", c, bus_a.m_axis_tvalid, (c == 5));
      end
      tick();
      start = 1'b0;
    end
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ovf_after: got %b, required 0", ovf_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_gaps();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d pending results, required 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
